// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI slave.
// Used by spi_slave_param and its testbench.
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin.
// Reset level comes in as a port so sck can idle at the live cpol.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= {STAGES{rst_val}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave, all four modes, one-word TX holding buffer.
// Define SPI_SLAVE_LSB_FIRST_EN to add the runtime lsb_first port.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL_WORD   = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_d;

    spi_mode_t        mode;
    spi_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] buf_q;
    logic              buf_full;

    logic sel;
    logic lead;
    logic trail;
    logic smp;
    logic shf;
    logic ss_fall;
    logic ss_rise;
    logic last;
    logic load;
    logic [DATA_W-1:0] ld_word;
    logic [DATA_W-1:0] ld_eff;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] rx_word;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .rst_val (cpol),
        .d       (sck),
        .q       (sck_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b1),
        .d       (ss_n),
        .q       (ss_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .rst_val (1'b0),
        .d       (mosi),
        .q       (mosi_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_d <= cpol;
        end else begin
            sck_d <= sck_s;
        end
    end

    assign sel     = (state == ACTIVE) && !ss_s;
    assign lead    = sel && (sck_d == mode.cpol) && (sck_s != mode.cpol);
    assign trail   = sel && (sck_d != mode.cpol) && (sck_s == mode.cpol);
    assign smp     = mode.cpha ? trail : lead;
    assign shf     = mode.cpha ? lead : trail;
    assign ss_fall = (state == IDLE) && !ss_s;
    assign ss_rise = (state == ACTIVE) && ss_s;
    assign last    = (bit_cnt == LAST);
    assign load    = ss_fall || (smp && last);
    assign ld_word = buf_full ? buf_q : FILL_WORD;
    assign rx_next = {rx_sr[DATA_W-2:0], mosi_s};

`ifdef SPI_SLAVE_LSB_FIRST_EN
    logic lsb;

    function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            lsb <= lsb_first;
        end else if (ss_s) begin
            lsb <= lsb_first;
        end
    end

    assign ld_eff  = lsb ? rev(ld_word) : ld_word;
    assign rx_word = lsb ? rev(rx_next) : rx_next;
`else
    assign ld_eff  = ld_word;
    assign rx_word = rx_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            mode        <= '{cpol: cpol, cpha: cpha};
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            buf_q       <= '0;
            buf_full    <= 1'b0;
            miso        <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;

            // mode is only followed while deselected, frozen for the frame
            if (ss_s) begin
                mode <= '{cpol: cpol, cpha: cpha};
            end

            unique case (1'b1)
                ss_fall: state <= ACTIVE;
                ss_rise: state <= IDLE;
                default: ;
            endcase

            if (ss_rise) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
                if (bit_cnt != '0) begin
                    frame_abort <= 1'b1;
                end
            end else if (smp) begin
                rx_sr   <= rx_next;
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
                if (last) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
            end

            // CPHA=0 skips the trailing edge right after a word load
            if (load) begin
                tx_sr       <= ld_eff;
                tx_underrun <= !buf_full;
                if (!mode.cpha) begin
                    miso <= ld_eff[DATA_W-1];
                end
            end else if (shf && (mode.cpha || bit_cnt != '0)) begin
                miso  <= mode.cpha ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
                tx_sr <= tx_sr << 1;
            end

            if (load && buf_full) begin
                buf_full <= 1'b0;
            end else if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_q    <= tx_data;
            end
        end
    end

    assign tx_ready = !buf_full;
    assign busy     = (state == ACTIVE);
    assign miso_oe  = (state == ACTIVE);

endmodule
